// File: rtl/multi_channel_tdc_timestamper.sv
// Multi-channel TDC front end: per-channel capture slots, round-robin arbiter, two-stage
// popcount encoder and a show-ahead output FIFO of {channel, coarse, fine} records.
module multi_channel_tdc_timestamper #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned STAGES      = 64,
  parameter int unsigned FINE_BITS   = 7,
  parameter int unsigned COARSE_BITS = 24,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CH_BITS     = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [CHANNELS-1:0]            chan_mask,
  input  logic [CHANNELS-1:0]            hit_valid,
  input  logic [CHANNELS*STAGES-1:0]     thermo,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_BITS-1:0]             out_channel,
  output logic [COARSE_BITS-1:0]         out_coarse,
  output logic [FINE_BITS-1:0]           out_fine,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [15:0]                    drop_count
);

  localparam int unsigned GroupW = STAGES / 4;
  localparam int unsigned PartW  = $clog2(GroupW + 1);
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW   = PtrW + 1;

  function automatic logic [PartW-1:0] popcnt(input logic [GroupW-1:0] v);
    logic [PartW-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < GroupW; b++) c = c + PartW'(v[b]);
    return c;
  endfunction

  logic [COARSE_BITS-1:0] coarse_q, coarse_d;
  logic [CHANNELS-1:0]    pend_q;
  logic [COARSE_BITS-1:0] slot_coarse_q [CHANNELS];
  logic [STAGES-1:0]      slot_thermo_q [CHANNELS];
  logic [CH_BITS-1:0]     ptr_q;
  logic [15:0]            drop_q, drop_d;

  logic                   s1_vld_q;
  logic [CH_BITS-1:0]     s1_ch_q;
  logic [COARSE_BITS-1:0] s1_coarse_q;
  logic [PartW-1:0]       s1_part_q [4];
  logic                   s2_vld_q;
  logic [CH_BITS-1:0]     s2_ch_q;
  logic [COARSE_BITS-1:0] s2_coarse_q;
  logic [FINE_BITS-1:0]   s2_fine_q;
  logic [FINE_BITS-1:0]   fine_sum;

  logic [CH_BITS-1:0]     mem_ch     [FIFO_DEPTH];
  logic [COARSE_BITS-1:0] mem_coarse [FIFO_DEPTH];
  logic [FINE_BITS-1:0]   mem_fine   [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]        level_q, level_d;

  logic                   credit_ok;
  logic                   gnt_valid;
  logic [CH_BITS-1:0]     gnt_idx;
  logic [CH_BITS-1:0]     cand;
  logic [CHANNELS-1:0]    gnt_oh;
  logic [CHANNELS-1:0]    hit_ok;
  logic                   push, pop;

  // Records already granted but not yet in the FIFO still need a free entry.
  assign credit_ok = (32'(level_q) + 32'(s1_vld_q) + 32'(s2_vld_q)) < FIFO_DEPTH;
  assign hit_ok    = hit_valid & chan_mask & {CHANNELS{enable}};

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned n = 0; n < CHANNELS; n++) begin
      cand = CH_BITS'((32'(ptr_q) + n) % CHANNELS);
      if (!gnt_valid && pend_q[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (!credit_ok) gnt_valid = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      gnt_oh[i] = gnt_valid && (32'(gnt_idx) == i);
    end
  end

  always_comb begin
    int unsigned ndrop;
    ndrop = 0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (hit_ok[i] && pend_q[i] && !gnt_oh[i]) ndrop = ndrop + 1;
    end
    drop_d   = ((32'(drop_q) + ndrop) > 32'hFFFF) ? 16'hFFFF : 16'(32'(drop_q) + ndrop);
    coarse_d = enable ? coarse_q + 1'b1 : '0;
  end

  always_comb begin
    fine_sum = '0;
    for (int unsigned g = 0; g < 4; g++) fine_sum = fine_sum + FINE_BITS'(s1_part_q[g]);
  end

  assign push = s2_vld_q;
  assign pop  = out_valid && out_ready;

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      coarse_q    <= '0;
      pend_q      <= '0;
      ptr_q       <= '0;
      drop_q      <= '0;
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_coarse_q <= '0;
      s2_vld_q    <= 1'b0;
      s2_ch_q     <= '0;
      s2_coarse_q <= '0;
      s2_fine_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        slot_coarse_q[i] <= '0;
        slot_thermo_q[i] <= '0;
      end
      for (int unsigned g = 0; g < 4; g++) s1_part_q[g] <= '0;
    end else begin
      coarse_q <= coarse_d;
      drop_q   <= drop_d;
      // A granted slot may be reloaded in the same cycle; the new hit wins.
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (hit_ok[i] && (!pend_q[i] || gnt_oh[i])) begin
          pend_q[i]        <= 1'b1;
          slot_coarse_q[i] <= coarse_q;
          slot_thermo_q[i] <= thermo[i*STAGES +: STAGES];
        end else if (gnt_oh[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
      s1_vld_q <= gnt_valid;
      if (gnt_valid) begin
        ptr_q       <= (32'(gnt_idx) + 1 == CHANNELS) ? '0 : gnt_idx + 1'b1;
        s1_ch_q     <= gnt_idx;
        s1_coarse_q <= slot_coarse_q[gnt_idx];
        for (int unsigned g = 0; g < 4; g++) begin
          s1_part_q[g] <= popcnt(slot_thermo_q[gnt_idx][g*GroupW +: GroupW]);
        end
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_ch_q     <= s1_ch_q;
        s2_coarse_q <= s1_coarse_q;
        s2_fine_q   <= fine_sum;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clock) begin
    if (reset && push) begin
      mem_ch[wr_ptr_q]     <= s2_ch_q;
      mem_coarse[wr_ptr_q] <= s2_coarse_q;
      mem_fine[wr_ptr_q]   <= s2_fine_q;
    end
  end

  assign out_valid   = (level_q != '0);
  assign out_channel = out_valid ? mem_ch[rd_ptr_q]     : '0;
  assign out_coarse  = out_valid ? mem_coarse[rd_ptr_q] : '0;
  assign out_fine    = out_valid ? mem_fine[rd_ptr_q]   : '0;
  assign fifo_level  = level_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_multi_channel_tdc_timestamper.sv
// Directed bench for multi_channel_tdc_timestamper with a queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_multi_channel_tdc_timestamper;

  localparam int CH  = 4;
  localparam int ST  = 64;
  localparam int FB  = 7;
  localparam int CB  = 8;   // narrow coarse counter so the wrap is reachable quickly
  localparam int FD  = 16;
  localparam int CHB = 2;

  logic              clk = 1'b0;
  logic              reset, enable, out_ready;
  logic [CH-1:0]     chan_mask, hit_valid;
  logic [CH*ST-1:0]  thermo;
  logic              out_valid;
  logic [CHB-1:0]    out_channel;
  logic [CB-1:0]     out_coarse;
  logic [FB-1:0]     out_fine;
  logic [$clog2(FD):0] fifo_level;
  logic [15:0]       drop_count;

  multi_channel_tdc_timestamper #(
    .CHANNELS(CH), .STAGES(ST), .FINE_BITS(FB), .COARSE_BITS(CB),
    .FIFO_DEPTH(FD), .CH_BITS(CHB)
  ) dut (
    .clock(clk), .reset(reset), .enable(enable), .chan_mask(chan_mask),
    .hit_valid(hit_valid), .thermo(thermo), .out_valid(out_valid), .out_ready(out_ready),
    .out_channel(out_channel), .out_coarse(out_coarse), .out_fine(out_fine),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pop_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slots, round-robin pick, 2-deep pipe, FIFO as a queue.
  typedef struct { int ch; int coarse; int fine; } rec_t;
  bit          m_init = 1'b0;
  int          m_coarse, m_ptr, m_drop, m_lvl, m_infl, m_g, m_c;
  bit          m_pend [CH];
  int          m_sc   [CH];
  logic [ST-1:0] m_st [CH];
  bit          m_s1v, m_s2v;
  rec_t        m_s1, m_s2, m_exp;
  rec_t        m_fifo [$];

  always @(posedge clk) begin
    if (!reset) begin
      m_init = 1'b1; m_coarse = 0; m_ptr = 0; m_drop = 0;
      m_s1v = 1'b0; m_s2v = 1'b0; m_fifo.delete();
      for (int i = 0; i < CH; i++) m_pend[i] = 1'b0;
    end else if (m_init) begin
      m_lvl = m_fifo.size(); m_infl = int'(m_s1v) + int'(m_s2v); m_g = -1;
      if (m_lvl + m_infl < FD)
        for (int n = 0; n < CH; n++) begin
          m_c = (m_ptr + n) % CH;
          if (m_g < 0 && m_pend[m_c]) m_g = m_c;
        end
      if (m_fifo.size() > 0 && out_ready) void'(m_fifo.pop_front());
      if (m_s2v) m_fifo.push_back(m_s2);
      m_s2v = m_s1v; m_s2 = m_s1;
      m_s1v = (m_g >= 0);
      if (m_g >= 0) begin
        m_s1 = '{m_g, m_sc[m_g], $countones(m_st[m_g])};
        m_pend[m_g] = 1'b0;
        m_ptr = (m_g + 1) % CH;
      end
      for (int i = 0; i < CH; i++)
        if (hit_valid[i] && chan_mask[i] && enable) begin
          if (m_pend[i]) m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
          else begin
            m_pend[i] = 1'b1; m_sc[i] = m_coarse; m_st[i] = thermo[i*ST +: ST];
          end
        end
      m_coarse = enable ? (m_coarse + 1) % (1 << CB) : 0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      if (m_fifo.size() > 0) m_exp = m_fifo[0];
      else m_exp = '{0, 0, 0};
      check("m_valid",  32'(out_valid),   32'(m_fifo.size() > 0));
      check("m_level",  32'(fifo_level),  32'(m_fifo.size()));
      check("m_drop",   32'(drop_count),  32'(m_drop));
      check("m_chan",   32'(out_channel), 32'(m_exp.ch));
      check("m_coarse", 32'(out_coarse),  32'(m_exp.coarse));
      check("m_fine",   32'(out_fine),    32'(m_exp.fine));
      if (out_valid && out_ready) pop_seen++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_thermo(input int ch, input logic [ST-1:0] v);
    thermo[ch*ST +: ST] = v;
  endtask

  task automatic expect_head(input string tag, input int ch, input int coarse, input int fine);
    check({tag, "_valid"},  32'(out_valid),   32'd1);
    check({tag, "_chan"},   32'(out_channel), 32'(ch));
    check({tag, "_coarse"}, 32'(out_coarse),  32'(coarse));
    check({tag, "_fine"},   32'(out_fine),    32'(fine));
  endtask

  int exp_coarse;
  int pop_base;

  initial begin
    reset = 1'b0; enable = 1'b0; out_ready = 1'b1;
    chan_mask = '1; hit_valid = '0; thermo = '0;
    repeat (3) tick;
    check("rst_valid", 32'(out_valid),  32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);
    check("rst_fine",  32'(out_fine),   32'd0);

    // Single hit on ch0 stamped at coarse 10
    reset = 1'b1; enable = 1'b1;
    repeat (10) tick;
    set_thermo(0, 64'h00FF); hit_valid = 4'b0001;
    tick;
    hit_valid = '0;
    tick; tick;
    check("lat_not_yet", 32'(out_valid), 32'd0);
    tick;
    expect_head("lat", 0, 10, 8);
    repeat (3) tick;

    // Hit on ch3 moves the pointer back to 0
    set_thermo(3, 64'h0); hit_valid = 4'b1000;
    tick;
    hit_valid = '0;
    repeat (6) tick;

    // Four simultaneous hits: ch0..ch3 on consecutive cycles, shared coarse
    set_thermo(0, 64'h0F7F); set_thermo(1, '1); set_thermo(2, 64'h0); set_thermo(3, 64'hFF);
    exp_coarse = m_coarse;
    hit_valid = 4'b1111;
    tick;
    hit_valid = '0;
    tick; tick; tick;
    expect_head("rr0", 0, exp_coarse, 11);
    tick;
    expect_head("rr1", 1, exp_coarse, 64);
    tick;
    expect_head("rr2", 2, exp_coarse, 0);
    tick;
    expect_head("rr3", 3, exp_coarse, 8);
    repeat (4) tick;

    // Back-pressure: 30 back-to-back ch1 hits, 16 queued, 1 pending, 13 dropped
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      set_thermo(1, ST'(k)); hit_valid = 4'b0010;
      tick;
    end
    hit_valid = '0;
    repeat (4) tick;
    check("bp_level", 32'(fifo_level), 32'd16);
    check("bp_drop",  32'(drop_count), 32'd13);
    pop_base = pop_seen;
    out_ready = 1'b1;
    repeat (25) tick;
    check("bp_pops",   32'(pop_seen - pop_base), 32'd17);
    check("bp_empty",  32'(fifo_level), 32'd0);

    // Masked channel and disabled hits are silently ignored
    out_ready = 1'b0; chan_mask = 4'b1011;
    set_thermo(2, '1); hit_valid = 4'b0100;
    tick;
    hit_valid = '0; chan_mask = '1; enable = 1'b0;
    tick;
    hit_valid = 4'b0001;
    tick;
    hit_valid = '0;
    repeat (6) tick;
    check("mask_level", 32'(fifo_level), 32'd0);
    check("mask_drop",  32'(drop_count), 32'd13);

    // Coarse wrap: hit at 2^CB-1, next hit stamped 0
    enable = 1'b1;
    repeat ((1 << CB) - 1) tick;
    set_thermo(0, 64'h1); hit_valid = 4'b0001;
    tick;
    set_thermo(1, 64'h3); hit_valid = 4'b0010;
    tick;
    hit_valid = '0;
    repeat (5) tick;
    check("wrap_level", 32'(fifo_level), 32'd2);
    expect_head("wrap_a", 0, (1 << CB) - 1, 1);
    out_ready = 1'b1;
    tick;
    expect_head("wrap_b", 1, 0, 2);
    repeat (3) tick;

    // Reset with five records queued discards everything
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_thermo(0, ST'(k)); hit_valid = 4'b0001;
      tick;
    end
    hit_valid = '0;
    repeat (4) tick;
    check("pre_rst_level", 32'(fifo_level), 32'd5);
    reset = 1'b0;
    tick;
    check("mid_rst_valid",  32'(out_valid),  32'd0);
    check("mid_rst_level",  32'(fifo_level), 32'd0);
    check("mid_rst_drop",   32'(drop_count), 32'd0);
    check("mid_rst_coarse", 32'(out_coarse), 32'd0);
    reset = 1'b1; out_ready = 1'b1;
    repeat (4) tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
